// File: rtl/alu_fixed_sync.sv
// Registered 4-bit ALU: one opcode per cycle, result and carry/flag land on the
// outputs one clock after the operands are sampled.
module alu_fixed_sync (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic [3:0] ALU_Sel,
  output logic [3:0] ALU_Out,
  output logic       CarryOut
);

  typedef enum logic [3:0] {
    OP_ADD  = 4'b0000,
    OP_SUB  = 4'b0001,
    OP_MUL  = 4'b0010,
    OP_DIV  = 4'b0011,
    OP_SHL  = 4'b0100,
    OP_SHR  = 4'b0101,
    OP_ROL  = 4'b0110,
    OP_ROR  = 4'b0111,
    OP_AND  = 4'b1000,
    OP_OR   = 4'b1001,
    OP_XOR  = 4'b1010,
    OP_NOR  = 4'b1011,
    OP_NAND = 4'b1100,
    OP_XNOR = 4'b1101,
    OP_GT   = 4'b1110,
    OP_EQ   = 4'b1111
  } opcode_e;

  logic [4:0] sum5;
  logic [4:0] diff5;
  logic [7:0] prod8;
  logic [3:0] aluOut_d, aluOut_q;
  logic       carry_d, carry_q;

  // Widened intermediates: the top bit of each holds carry, borrow or overflow.
  assign sum5  = {1'b0, A} + {1'b0, B};
  assign diff5 = {1'b0, A} - {1'b0, B};
  assign prod8 = {4'b0000, A} * {4'b0000, B};

  always_comb begin
    aluOut_d = 4'h0;
    carry_d  = 1'b0;
    case (opcode_e'(ALU_Sel))
      OP_ADD: begin
        aluOut_d = sum5[3:0];
        carry_d  = sum5[4];
      end
      OP_SUB: begin
        aluOut_d = diff5[3:0];
        carry_d  = diff5[4];
      end
      OP_MUL: begin
        aluOut_d = prod8[3:0];
        carry_d  = |prod8[7:4];
      end
      OP_DIV: begin
        // Divide-by-zero saturates the result and raises the flag.
        if (B == 4'h0) begin
          aluOut_d = 4'hF;
          carry_d  = 1'b1;
        end else begin
          aluOut_d = A / B;
        end
      end
      OP_SHL: begin
        aluOut_d = {A[2:0], 1'b0};
        carry_d  = A[3];
      end
      OP_SHR: begin
        aluOut_d = {1'b0, A[3:1]};
        carry_d  = A[0];
      end
      OP_ROL:  aluOut_d = {A[2:0], A[3]};
      OP_ROR:  aluOut_d = {A[0], A[3:1]};
      OP_AND:  aluOut_d = A & B;
      OP_OR:   aluOut_d = A | B;
      OP_XOR:  aluOut_d = A ^ B;
      OP_NOR:  aluOut_d = ~(A | B);
      OP_NAND: aluOut_d = ~(A & B);
      OP_XNOR: aluOut_d = ~(A ^ B);
      OP_GT:   aluOut_d = {3'b000, (A > B)};
      OP_EQ:   aluOut_d = {3'b000, (A == B)};
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      aluOut_q <= 4'h0;
      carry_q  <= 1'b0;
    end else begin
      aluOut_q <= aluOut_d;
      carry_q  <= carry_d;
    end
  end

  assign ALU_Out  = aluOut_q;
  assign CarryOut = carry_q;

endmodule

// File: tb/tb_alu_fixed_sync.sv
// Self-checking bench for alu_fixed_sync: directed sweeps, spot checks and
// randomized traffic compared against an arithmetic reference model.
module tb_alu_fixed_sync;

  logic       clk;
  logic       reset;
  logic [3:0] A;
  logic [3:0] B;
  logic [3:0] ALU_Sel;
  logic [3:0] ALU_Out;
  logic       CarryOut;

  int checks;
  int failures;

  alu_fixed_sync dut (
    .clk      (clk),
    .reset    (reset),
    .A        (A),
    .B        (B),
    .ALU_Sel  (ALU_Sel),
    .ALU_Out  (ALU_Out),
    .CarryOut (CarryOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model in plain integer arithmetic; returns {carry, result}.
  function automatic logic [4:0] refModel(input int a, input int b, input int sel);
    int r;
    int c;
    logic [4:0] res;
    r = 0;
    c = 0;
    case (sel)
      0:  begin r = a + b; c = (r > 15) ? 1 : 0; end
      1:  begin r = a - b + 16; c = (a < b) ? 1 : 0; end
      2:  begin r = a * b; c = (r > 15) ? 1 : 0; end
      3:  begin
            if (b == 0) begin r = 15; c = 1; end
            else r = a / b;
          end
      4:  begin r = a * 2; c = (a >= 8) ? 1 : 0; end
      5:  begin r = a / 2; c = a % 2; end
      6:  r = (a * 2) % 16 + a / 8;
      7:  r = a / 2 + (a % 2) * 8;
      8:  r = a & b;
      9:  r = a | b;
      10: r = a ^ b;
      11: r = 15 - (a | b);
      12: r = 15 - (a & b);
      13: r = 15 - (a ^ b);
      14: r = (a > b) ? 1 : 0;
      15: r = (a == b) ? 1 : 0;
      default: r = 0;
    endcase
    r = r % 16;
    res = {c[0], r[3:0]};
    return res;
  endfunction

  // Drive one operation, clock it in, and return #1 after the edge.
  task automatic applyStimulus(input logic [3:0] a, input logic [3:0] b, input logic [3:0] sel);
    A = a;
    B = b;
    ALU_Sel = sel;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    applyStimulus(4'd5, 4'd3, 4'b0000);
    checks++;
    if ({CarryOut, ALU_Out} !== 5'b00000) begin
      failures++;
      $display("[TB] FAIL reset_clear got=%b/%h exp=0/0", CarryOut, ALU_Out);
    end
    reset = 1'b0;
    applyStimulus(4'd5, 4'd3, 4'b0000);
    checks++;
    if ({CarryOut, ALU_Out} !== 5'b01000) begin
      failures++;
      $display("[TB] FAIL reset_release got=%b/%h exp=0/8", CarryOut, ALU_Out);
    end
    reset = 1'b1;
    applyStimulus(4'd15, 4'd1, 4'b0000);
    checks++;
    if ({CarryOut, ALU_Out} !== 5'b00000) begin
      failures++;
      $display("[TB] FAIL reset_priority got=%b/%h exp=0/0", CarryOut, ALU_Out);
    end
    reset = 1'b0;
  endtask

  task automatic test_add_sweep();
    logic [4:0] exp;
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        exp = refModel(a, b, 0);
        applyStimulus(4'(a), 4'(b), 4'b0000);
        checks++;
        if ({CarryOut, ALU_Out} !== exp) begin
          failures++;
          $display("[TB] FAIL add a=%0d b=%0d got=%b/%0d exp=%b/%0d", a, b, CarryOut, ALU_Out, exp[4], exp[3:0]);
        end
      end
    end
    applyStimulus(4'd15, 4'd1, 4'b0000);
    checks++;
    if ({CarryOut, ALU_Out} !== 5'b10000) begin
      failures++;
      $display("[TB] FAIL add_15_1 got=%b/%0d exp=1/0", CarryOut, ALU_Out);
    end
    applyStimulus(4'd7, 4'd8, 4'b0000);
    checks++;
    if ({CarryOut, ALU_Out} !== 5'b01111) begin
      failures++;
      $display("[TB] FAIL add_7_8 got=%b/%0d exp=0/15", CarryOut, ALU_Out);
    end
  endtask

  task automatic test_mul_sweep();
    logic [4:0] exp;
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        exp = refModel(a, b, 2);
        applyStimulus(4'(a), 4'(b), 4'b0010);
        checks++;
        if ({CarryOut, ALU_Out} !== exp) begin
          failures++;
          $display("[TB] FAIL mul a=%0d b=%0d got=%b/%0d exp=%b/%0d", a, b, CarryOut, ALU_Out, exp[4], exp[3:0]);
        end
      end
    end
    applyStimulus(4'd3, 4'd5, 4'b0010);
    checks++;
    if ({CarryOut, ALU_Out} !== 5'b01111) begin
      failures++;
      $display("[TB] FAIL mul_3_5 got=%b/%0d exp=0/15", CarryOut, ALU_Out);
    end
    applyStimulus(4'd4, 4'd4, 4'b0010);
    checks++;
    if ({CarryOut, ALU_Out} !== 5'b10000) begin
      failures++;
      $display("[TB] FAIL mul_4_4 got=%b/%0d exp=1/0", CarryOut, ALU_Out);
    end
    applyStimulus(4'd15, 4'd15, 4'b0010);
    checks++;
    if ({CarryOut, ALU_Out} !== 5'b10001) begin
      failures++;
      $display("[TB] FAIL mul_15_15 got=%b/%0d exp=1/1", CarryOut, ALU_Out);
    end
  endtask

  task automatic test_shift_rotate();
    logic [4:0] exp;
    int ops[4] = '{4, 5, 6, 7};
    foreach (ops[k]) begin
      for (int a = 0; a < 16; a++) begin
        exp = refModel(a, 0, ops[k]);
        applyStimulus(4'(a), 4'($urandom), 4'(ops[k]));
        checks++;
        if ({CarryOut, ALU_Out} !== exp) begin
          failures++;
          $display("[TB] FAIL shift op=%0d a=%0d got=%b/%0d exp=%b/%0d", ops[k], a, CarryOut, ALU_Out, exp[4], exp[3:0]);
        end
      end
    end
    applyStimulus(4'd9, 4'($urandom), 4'b0100);
    checks++;
    if ({CarryOut, ALU_Out} !== 5'b10010) begin
      failures++;
      $display("[TB] FAIL shl_9 got=%b/%0d exp=1/2", CarryOut, ALU_Out);
    end
    applyStimulus(4'd1, 4'($urandom), 4'b0111);
    checks++;
    if ({CarryOut, ALU_Out} !== 5'b01000) begin
      failures++;
      $display("[TB] FAIL ror_1 got=%b/%0d exp=0/8", CarryOut, ALU_Out);
    end
    applyStimulus(4'd6, 4'($urandom), 4'b0111);
    checks++;
    if ({CarryOut, ALU_Out} !== 5'b00011) begin
      failures++;
      $display("[TB] FAIL ror_6 got=%b/%0d exp=0/3", CarryOut, ALU_Out);
    end
  endtask

  task automatic test_logic_compare();
    logic [4:0] exp;
    int ops[2] = '{8, 14};
    foreach (ops[k]) begin
      for (int a = 0; a < 16; a++) begin
        for (int b = 0; b < 16; b++) begin
          exp = refModel(a, b, ops[k]);
          applyStimulus(4'(a), 4'(b), 4'(ops[k]));
          checks++;
          if ({CarryOut, ALU_Out} !== exp) begin
            failures++;
            $display("[TB] FAIL logic op=%0d a=%0d b=%0d got=%b/%0d exp=%b/%0d", ops[k], a, b, CarryOut, ALU_Out, exp[4], exp[3:0]);
          end
        end
      end
    end
    applyStimulus(4'd12, 4'd10, 4'b1000);
    checks++;
    if ({CarryOut, ALU_Out} !== 5'b01000) begin
      failures++;
      $display("[TB] FAIL and_12_10 got=%b/%0d exp=0/8", CarryOut, ALU_Out);
    end
    applyStimulus(4'd5, 4'd3, 4'b1110);
    checks++;
    if ({CarryOut, ALU_Out} !== 5'b00001) begin
      failures++;
      $display("[TB] FAIL gt_5_3 got=%b/%0d exp=0/1", CarryOut, ALU_Out);
    end
    applyStimulus(4'd3, 4'd5, 4'b1110);
    checks++;
    if ({CarryOut, ALU_Out} !== 5'b00000) begin
      failures++;
      $display("[TB] FAIL gt_3_5 got=%b/%0d exp=0/0", CarryOut, ALU_Out);
    end
    applyStimulus(4'd7, 4'd7, 4'b1110);
    checks++;
    if ({CarryOut, ALU_Out} !== 5'b00000) begin
      failures++;
      $display("[TB] FAIL gt_7_7 got=%b/%0d exp=0/0", CarryOut, ALU_Out);
    end
  endtask

  task automatic test_sub_div();
    applyStimulus(4'd0, 4'd1, 4'b0001);
    checks++;
    if ({CarryOut, ALU_Out} !== 5'b11111) begin
      failures++;
      $display("[TB] FAIL sub_0_1 got=%b/%0d exp=1/15", CarryOut, ALU_Out);
    end
    applyStimulus(4'd9, 4'd2, 4'b0011);
    checks++;
    if ({CarryOut, ALU_Out} !== 5'b00100) begin
      failures++;
      $display("[TB] FAIL div_9_2 got=%b/%0d exp=0/4", CarryOut, ALU_Out);
    end
    applyStimulus(4'd7, 4'd0, 4'b0011);
    checks++;
    if ({CarryOut, ALU_Out} !== 5'b11111) begin
      failures++;
      $display("[TB] FAIL div_7_0 got=%b/%0d exp=1/15", CarryOut, ALU_Out);
    end
  endtask

  // Opcode changes every cycle; inputs are also disturbed between edges to
  // confirm the registered outputs hold.
  task automatic test_back_to_back();
    logic [4:0] exp;
    int a;
    int b;
    for (int i = 0; i < 64; i++) begin
      a = $urandom_range(0, 15);
      b = $urandom_range(0, 15);
      exp = refModel(a, b, i % 16);
      applyStimulus(4'(a), 4'(b), 4'(i % 16));
      checks++;
      if ({CarryOut, ALU_Out} !== exp) begin
        failures++;
        $display("[TB] FAIL b2b op=%0d a=%0d b=%0d got=%b/%0d exp=%b/%0d", i % 16, a, b, CarryOut, ALU_Out, exp[4], exp[3:0]);
      end
      A = 4'($urandom);
      B = 4'($urandom);
      ALU_Sel = 4'($urandom);
      #3;
      checks++;
      if ({CarryOut, ALU_Out} !== exp) begin
        failures++;
        $display("[TB] FAIL hold op=%0d got=%b/%0d exp=%b/%0d", i % 16, CarryOut, ALU_Out, exp[4], exp[3:0]);
      end
    end
  endtask

  task automatic test_random();
    logic [4:0] exp;
    int a;
    int b;
    int sel;
    for (int i = 0; i < 400; i++) begin
      a = $urandom_range(0, 15);
      b = $urandom_range(0, 15);
      sel = $urandom_range(0, 15);
      exp = refModel(a, b, sel);
      applyStimulus(4'(a), 4'(b), 4'(sel));
      checks++;
      if ({CarryOut, ALU_Out} !== exp) begin
        failures++;
        $display("[TB] FAIL random op=%0d a=%0d b=%0d got=%b/%0d exp=%b/%0d", sel, a, b, CarryOut, ALU_Out, exp[4], exp[3:0]);
      end
    end
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b0;
    A = 4'h0;
    B = 4'h0;
    ALU_Sel = 4'h0;
    test_reset();
    test_add_sweep();
    test_mul_sweep();
    test_shift_rotate();
    test_logic_compare();
    test_sub_div();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
